// File: rtl/pipelined_add_sub.sv
// rtl/pipelined_add_sub.sv - parametrised pipelined adder/subtractor with valid/ready handshakes
module pipelined_add_sub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW = WIDTH / STAGES;

  if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_add_sub: illegal WIDTH/STAGES combination");
  end

  // Global enable: the whole pipe freezes while the output beat is refused.
  logic             en;

  // Inputs seen by stage k: index 0 comes from the ports, index k>0 from stage k-1's register.
  logic             st_v [STAGES];
  logic [WIDTH-1:0] st_a [STAGES];
  logic [WIDTH-1:0] st_b [STAGES];
  logic [WIDTH-1:0] st_s [STAGES];
  logic             st_c [STAGES];

  assign en       = ~(out_valid & ~out_ready);
  assign in_ready = en;

  // Subtraction is a + ~b + ~cin, so the borrow-in folds into the initial carry.
  assign st_v[0] = in_valid;
  assign st_a[0] = a;
  assign st_b[0] = sub ? ~b : b;
  assign st_c[0] = sub ? ~cin : cin;
  assign st_s[0] = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SW:0]      slice;
    logic [WIDTH-1:0] nxt_s;

    assign slice = {1'b0, st_a[k][k*SW +: SW]}
                 + {1'b0, st_b[k][k*SW +: SW]}
                 + {{SW{1'b0}}, st_c[k]};

    // Splice this stage's slice into the partial sum handed down the pipe.
    always_comb begin
      nxt_s              = st_s[k];
      nxt_s[k*SW +: SW]  = slice[SW-1:0];
    end

    if (k < STAGES - 1) begin : g_mid
      logic             v_q;
      logic             c_q;
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic [WIDTH-1:0] s_q;

      // Skew register: valid advances with the pipe, payload only loads under a real beat.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_q <= 1'b0;
          c_q <= 1'b0;
          a_q <= '0;
          b_q <= '0;
          s_q <= '0;
        end else if (en) begin
          v_q <= st_v[k];
          if (st_v[k]) begin
            c_q <= slice[SW];
            a_q <= st_a[k];
            b_q <= st_b[k];
            s_q <= nxt_s;
          end
        end
      end

      assign st_v[k+1] = v_q;
      assign st_c[k+1] = c_q;
      assign st_a[k+1] = a_q;
      assign st_b[k+1] = b_q;
      assign st_s[k+1] = s_q;
    end else begin : g_last
      // Result register; carry into the MSB is recovered as sum ^ a ^ bx at bit WIDTH-1.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_valid <= 1'b0;
          sum       <= '0;
          cout      <= 1'b0;
          ovf       <= 1'b0;
        end else if (en) begin
          out_valid <= st_v[k];
          if (st_v[k]) begin
            sum  <= nxt_s;
            cout <= slice[SW];
            ovf  <= nxt_s[WIDTH-1] ^ st_a[k][WIDTH-1] ^ st_b[k][WIDTH-1] ^ slice[SW];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb/tb_pipelined_add_sub.sv - self-checking bench for pipelined_add_sub
module tb_pipelined_add_sub;

  int checks   = 0;
  int failures = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: exact integer arithmetic, result packed as {ovf, cout, sum}.
  function automatic logic [33:0] model32(input logic [31:0] x, input logic [31:0] y,
                                          input logic c, input logic s);
    longint ux, uy, sx, sy, ci, r, sr;
    logic co, ov;
    ux = longint'({32'h0, x});
    uy = longint'({32'h0, y});
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ci = longint'({63'h0, c});
    if (s) begin
      r  = ux - uy - ci;
      sr = sx - sy - ci;
      co = (r >= 0);
    end else begin
      r  = ux + uy + ci;
      sr = sx + sy + ci;
      co = r[32];
    end
    ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return {ov, co, r[31:0]};
  endfunction

  // ---------------- main DUT, WIDTH=32 STAGES=4 ----------------
  logic        rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [31:0] a, b, sum;

  pipelined_add_sub #(.WIDTH(32), .STAGES(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  logic [33:0] q_main[$];
  int          retired = 0;
  logic        first_pending = 1'b1;
  logic [31:0] first_sum = '0;

  always @(negedge clk) begin
    if (rst) begin
      q_main.delete();
      first_pending = 1'b1;
    end else begin
      if (out_valid && out_ready) begin
        chk(q_main.size() > 0, "main_unexpected_beat", {ovf, cout, sum}, 0);
        if (q_main.size() > 0) begin
          logic [33:0] e;
          e = q_main.pop_front();
          chk({ovf, cout, sum} == e, "main_stream_result", {ovf, cout, sum}, e);
        end
        if (first_pending) begin
          first_sum     = sum;
          first_pending = 1'b0;
        end
        retired++;
      end
      if (in_valid && in_ready) q_main.push_back(model32(a, b, cin, sub));
    end
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vt[8];

  task automatic rand_ops();
    a   = $urandom();
    b   = $urandom();
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
  endtask

  task automatic send_one(input vec_t v, input int idx);
    int lat;
    @(posedge clk); #1;
    in_valid = 1'b1; a = v.a; b = v.b; cin = v.cin; sub = v.sub;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    chk(lat == 4, $sformatf("vec%0d_latency", idx), lat, 4);
    chk({out_valid, ovf, cout, sum} == {1'b1, v.ov, v.co, v.s},
        $sformatf("vec%0d_result", idx), {out_valid, ovf, cout, sum}, {1'b1, v.ov, v.co, v.s});
  endtask

  initial begin
    int base;
    logic [35:0] snap;

    vt[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vt[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vt[2] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vt[3] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0};
    vt[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vt[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vt[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vt[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    chk(out_valid == 1'b0, "reset_out_valid", out_valid, 0);
    chk(in_ready == 1'b1, "reset_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk(out_valid == 1'b0, "post_reset_out_valid", out_valid, 0);

    // directed vectors
    for (int i = 0; i < 8; i++) send_one(vt[i], i);

    // back-to-back streaming
    @(posedge clk); #1;
    base = retired;
    for (int i = 0; i < 100; i++) begin
      if (i != 0) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      rand_ops();
      @(negedge clk);
      chk(in_ready == 1'b1, "stream_in_ready", in_ready, 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk(retired - base == 100, "stream_throughput", retired - base, 100);
    chk(q_main.size() == 0, "stream_drained", q_main.size(), 0);

    // backpressure mid-stream
    snap = '0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      out_ready = !(i >= 10 && i < 15);
      in_valid  = 1'b1;
      rand_ops();
      @(negedge clk);
      if (i == 10) begin
        snap = {1'b0, out_valid, ovf, cout, sum};
        chk(out_valid == 1'b1, "bp_valid_at_stall", out_valid, 1);
      end
      if (i >= 10 && i < 15) chk(in_ready == 1'b0, "bp_in_ready_low", in_ready, 0);
      if (i > 10 && i < 15)
        chk({1'b0, out_valid, ovf, cout, sum} == snap, "bp_output_stable",
            {out_valid, ovf, cout, sum}, snap);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int t = 0; t < 20 && q_main.size() != 0; t++) @(posedge clk);
    @(negedge clk); #1;
    chk(q_main.size() == 0, "bp_drained", q_main.size(), 0);

    // reset with the pipe full and stalled
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rand_ops();
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk(out_valid == 1'b1, "rst_pre_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk(out_valid == 1'b0, "rst_async_clear", out_valid, 0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; sub = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      rand_ops();
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int t = 0; t < 20 && q_main.size() != 0; t++) @(posedge clk);
    @(negedge clk); #1;
    chk(q_main.size() == 0, "rst_post_drained", q_main.size(), 0);
    chk({first_pending, first_sum} == {1'b0, 32'h2345_6789}, "rst_first_result",
        {first_pending, first_sum}, {1'b0, 32'h2345_6789});

    // wait for the parameter sweep instances
    for (int t = 0; t < 5000 && !(g_sw[0].sdone && g_sw[1].sdone && g_sw[2].sdone); t++)
      @(posedge clk);
    chk(g_sw[0].sdone && g_sw[1].sdone && g_sw[2].sdone, "sweep_completed",
        {g_sw[0].sdone, g_sw[1].sdone, g_sw[2].sdone}, 3'b111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- parameter sweep: (8,1), (8,8), (64,4) ----------------
  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int W = (g == 2) ? 64 : 8;
    localparam int S = (g == 0) ? 1 : (g == 1) ? 8 : 4;

    logic         srst, siv, sir, sov, sor, scin, ssub, scout, sovf;
    logic [W-1:0] sa, sb, ssum;
    logic [W+1:0] sq[$];
    logic         sdone = 1'b0;

    pipelined_add_sub #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk(clk), .rst(srst), .in_valid(siv), .in_ready(sir),
      .a(sa), .b(sb), .cin(scin), .sub(ssub),
      .out_valid(sov), .out_ready(sor),
      .sum(ssum), .cout(scout), .ovf(sovf)
    );

    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c, input logic s);
      logic [W+1:0]        ux, uy, uc, r;
      logic signed [W+1:0] sx, sy, sr, smax, smin;
      logic                co, ov;
      ux   = {2'b00, x};
      uy   = {2'b00, y};
      uc   = {{(W+1){1'b0}}, c};
      sx   = {{2{x[W-1]}}, x};
      sy   = {{2{y[W-1]}}, y};
      smax = {3'b000, {(W-1){1'b1}}};
      smin = {3'b111, {(W-1){1'b0}}};
      if (s) begin
        r  = ux - uy - uc;
        co = (ux >= uy + uc);
        sr = sx - sy - $signed(uc);
      end else begin
        r  = ux + uy + uc;
        co = r[W];
        sr = sx + sy + $signed(uc);
      end
      ov = (sr > smax) || (sr < smin);
      return {ov, co, r[W-1:0]};
    endfunction

    function automatic logic [W-1:0] rop();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      case ($urandom_range(0, 5))
        0:       return '1;
        1:       return '0;
        2:       return {1'b1, {(W-1){1'b0}}};
        3:       return {1'b0, {(W-1){1'b1}}};
        default: return r[W-1:0];
      endcase
    endfunction

    always @(negedge clk) begin
      if (srst) begin
        sq.delete();
      end else begin
        if (sov && sor) begin
          chk(sq.size() > 0, $sformatf("sweep%0d_unexpected_beat", g), {sovf, scout, ssum}, 0);
          if (sq.size() > 0) begin
            logic [W+1:0] e;
            e = sq.pop_front();
            chk({sovf, scout, ssum} == e, $sformatf("sweep%0d_result", g), {sovf, scout, ssum}, e);
          end
        end
        if (siv && sir) sq.push_back(model(sa, sb, scin, ssub));
      end
    end

    initial begin
      int lat;
      srst = 1'b1; siv = 1'b0; sor = 1'b1;
      sa = '0; sb = '0; scin = 1'b0; ssub = 1'b0;
      repeat (2) @(negedge clk);
      chk(sov == 1'b0, $sformatf("sweep%0d_reset_valid", g), sov, 0);
      @(posedge clk); #1;
      srst = 1'b0;

      // single beat latency with no stall
      @(posedge clk); #1;
      siv = 1'b1; sa = rop(); sb = rop(); scin = 1'($urandom_range(0, 1)); ssub = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      siv = 1'b0;
      lat = 1;
      while (lat < 40) begin
        @(negedge clk);
        if (sov) break;
        @(posedge clk);
        lat++;
      end
      chk(lat == S, $sformatf("sweep%0d_latency", g), lat, S);

      // random valid/ready traffic
      for (int i = 0; i < 400; i++) begin
        @(posedge clk); #1;
        siv  = ($urandom_range(0, 3) != 0);
        sor  = ($urandom_range(0, 3) != 0);
        sa   = rop();
        sb   = rop();
        scin = 1'($urandom_range(0, 1));
        ssub = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      siv = 1'b0; sor = 1'b1;
      for (int t = 0; t < S + 10 && sq.size() != 0; t++) @(posedge clk);
      @(negedge clk); #1;
      chk(sq.size() == 0, $sformatf("sweep%0d_drained", g), sq.size(), 0);
      sdone = 1'b1;
    end
  end

endmodule
